// File: rtl/idct_calculator.sv
// ---------------------------------------------------------------------------
// idct_calculator
//
// 2-D 8x8 inverse DCT: X = A^T * F * A, where A is the orthonormal DCT-II
// matrix in Q14. The block is processed as two matrix passes over one shared
// array of 64 multiply-accumulators:
//   PASS1 : acc[i][j] += A[k][i] * F[k][j]            (k = 0..7)
//   RND1  : T = sat16(round(acc)), acc cleared
//   PASS2 : acc[i][j] += T[i][k] * A[k][j]            (k = 0..7)
//   OUT   : o_pixel = clip(round(acc)) held with o_valid = 1
//
// Ports
//   clk      clock
//   n_rst    synchronous active-low reset; also aborts a block in flight
//   i_start  a block is present on i_coef (taken only while o_ready = 1)
//   i_coef   64 signed coefficients, packed [row][col], element (r,c) at
//            bits [(r*8+c)*COEF_BITWIDTH +: COEF_BITWIDTH]
//   i_wait   downstream stall, freezes every step while high
//   o_ready  ready to accept i_start (IDLE only)
//   o_pixel  64 reconstructed samples, packed [row][col] like i_coef
//   o_valid  o_pixel holds a complete block
//
// Optional feature macro: IDCT_LEVEL_SHIFT_EN
//   defined   : 2^(PIX_BITWIDTH-1) is added after rounding and the result is
//               clipped to unsigned [0, 2^PIX_BITWIDTH-1]
//   undefined : signed output clipped to [-2^(PIX_BITWIDTH-1), 2^(PIX_BITWIDTH-1)-1]
//
// Timing without stalls: accept in C0, PASS1 C1..C8, RND1 C9, PASS2 C10..C17,
// o_valid in C18 for one cycle, o_ready again in C19.
// Only MCU_SIZE = 8 is supported.
// ---------------------------------------------------------------------------
module idct_calculator #(
  parameter int MCU_SIZE      = 8,
  parameter int COEF_BITWIDTH = 12,
  parameter int PIX_BITWIDTH  = 8,
  parameter int FRAC_BITS     = 14
) (
  input  logic                                        clk,
  input  logic                                        n_rst,
  input  logic                                        i_start,
  input  logic [MCU_SIZE*MCU_SIZE*COEF_BITWIDTH-1:0]  i_coef,
  input  logic                                        i_wait,
  output logic                                        o_ready,
  output logic [MCU_SIZE*MCU_SIZE*PIX_BITWIDTH-1:0]   o_pixel,
  output logic                                        o_valid
);

  localparam int N  = MCU_SIZE;
  localparam int CW = 16;   // cosine constants and intermediate T
  localparam int PW = 32;   // product width
  localparam int AW = 36;   // accumulator width, wide enough for full-range input

  localparam logic signed [AW-1:0] RND_HALF = AW'(2 ** (FRAC_BITS - 1));
  localparam logic signed [AW-1:0] T_MAX    = AW'(32767);
  localparam logic signed [AW-1:0] T_MIN    = AW'(-32768);
`ifdef IDCT_LEVEL_SHIFT_EN
  localparam logic signed [AW-1:0] PIX_OFS  = AW'(2 ** (PIX_BITWIDTH - 1));
  localparam logic signed [AW-1:0] PIX_MAX  = AW'(2 ** PIX_BITWIDTH - 1);
  localparam logic signed [AW-1:0] PIX_MIN  = AW'(0);
`else
  localparam logic signed [AW-1:0] PIX_MAX  = AW'(2 ** (PIX_BITWIDTH - 1) - 1);
  localparam logic signed [AW-1:0] PIX_MIN  = AW'(-(2 ** (PIX_BITWIDTH - 1)));
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    RND1  = 3'd2,
    PASS2 = 3'd3,
    OUT   = 3'd4
  } state_t;

  // A[k][n] = round(c(k) * cos((2n+1)k*pi/16) * 2^14).
  // The angle index m = (2n+1)k is folded into the first quadrant so only
  // seven magnitudes are stored; c(0) rows are the constant 1/sqrt(8).
  function automatic logic signed [CW-1:0] a_coef(input logic [2:0] k,
                                                  input logic [2:0] n);
    int                     m;
    logic                   neg;
    logic signed [CW-1:0]   mag;
    m = ((2 * int'(n) + 1) * int'(k)) % 32;
    if (m > 16) m = 32 - m;          // cos(2pi - x) = cos(x)
    neg = (m > 8);
    if (neg) m = 16 - m;             // cos(pi - x) = -cos(x)
    case (m)
      1:       mag = 16'sd8035;
      2:       mag = 16'sd7568;
      3:       mag = 16'sd6811;
      4:       mag = 16'sd5793;
      5:       mag = 16'sd4551;
      6:       mag = 16'sd3135;
      7:       mag = 16'sd1598;
      default: mag = 16'sd0;
    endcase
    if (k == 3'd0) begin
      mag = 16'sd5793;
      neg = 1'b0;
    end
    return neg ? -mag : mag;
  endfunction

  state_t                      state_reg;
  logic [2:0]                  k_reg;
  logic signed [COEF_BITWIDTH-1:0] f_reg   [N][N];
  logic signed [CW-1:0]        t_reg    [N][N];
  logic signed [AW-1:0]        acc_reg  [N][N];

  logic signed [AW-1:0]        acc_next [N][N];
  logic signed [CW-1:0]        t_next   [N][N];
  logic [PIX_BITWIDTH-1:0]     pix_next [N][N];
  logic signed [CW-1:0]        a_k      [N];    // row k of A
  logic                        pass2;

  assign pass2 = (state_reg == PASS2);

  // Row k of A serves as A[k][i] in PASS1 and as A[k][j] in PASS2.
  for (genvar gi = 0; gi < N; gi++) begin : g_coef
    assign a_k[gi] = a_coef(k_reg, 3'(gi));
  end

  // 64-MAC array with its rounding / saturation / clipping datapath.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [CW-1:0] op_a;
      logic signed [CW-1:0] op_b;
      logic signed [PW-1:0] prod;
      logic signed [AW-1:0] rnd_t;
      logic signed [AW-1:0] rnd_p;
      logic signed [AW-1:0] shf;

      assign op_a = pass2 ? t_reg[gi][k_reg] : a_k[gi];
      assign op_b = pass2 ? a_k[gj] : CW'(f_reg[k_reg][gj]);
      assign prod = PW'(op_a) * PW'(op_b);
      assign acc_next[gi][gj] = acc_reg[gi][gj] + AW'(prod);

      // Intermediate T: round-half-up then saturate to 16 bits.
      assign rnd_t = (acc_reg[gi][gj] + RND_HALF) >>> FRAC_BITS;

      always_comb begin
        t_next[gi][gj] = rnd_t[CW-1:0];
        if (rnd_t > T_MAX)
          t_next[gi][gj] = T_MAX[CW-1:0];
        else if (rnd_t < T_MIN)
          t_next[gi][gj] = T_MIN[CW-1:0];
      end

      // The output is taken from the sum that includes the last PASS2
      // product so that o_pixel is registered on the same edge that
      // enters OUT.
      assign rnd_p = (acc_next[gi][gj] + RND_HALF) >>> FRAC_BITS;
`ifdef IDCT_LEVEL_SHIFT_EN
      assign shf = rnd_p + PIX_OFS;
`else
      assign shf = rnd_p;
`endif

      always_comb begin
        pix_next[gi][gj] = shf[PIX_BITWIDTH-1:0];
        if (shf > PIX_MAX)
          pix_next[gi][gj] = PIX_MAX[PIX_BITWIDTH-1:0];
        else if (shf < PIX_MIN)
          pix_next[gi][gj] = PIX_MIN[PIX_BITWIDTH-1:0];
      end
    end
  end

  // Control FSM and all state. A waited cycle changes nothing except that
  // IDLE still accepts a block.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      k_reg     <= 3'd0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_pixel   <= '0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          acc_reg[r][c] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            for (int r = 0; r < N; r++)
              for (int c = 0; c < N; c++) begin
                f_reg[r][c]   <= i_coef[(r*N+c)*COEF_BITWIDTH +: COEF_BITWIDTH];
                acc_reg[r][c] <= '0;   // drop the previous block's sums
              end
            k_reg     <= 3'd0;
            o_ready   <= 1'b0;
            state_reg <= PASS1;
          end
        end

        PASS1: begin
          if (!i_wait) begin
            for (int r = 0; r < N; r++)
              for (int c = 0; c < N; c++)
                acc_reg[r][c] <= acc_next[r][c];
            k_reg <= k_reg + 3'd1;
            if (k_reg == 3'd7)
              state_reg <= RND1;
          end
        end

        RND1: begin
          if (!i_wait) begin
            for (int r = 0; r < N; r++)
              for (int c = 0; c < N; c++) begin
                t_reg[r][c]   <= t_next[r][c];
                acc_reg[r][c] <= '0;
              end
            state_reg <= PASS2;   // k_reg has wrapped back to 0
          end
        end

        PASS2: begin
          if (!i_wait) begin
            for (int r = 0; r < N; r++)
              for (int c = 0; c < N; c++)
                acc_reg[r][c] <= acc_next[r][c];
            k_reg <= k_reg + 3'd1;
            if (k_reg == 3'd7) begin
              for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                  o_pixel[(r*N+c)*PIX_BITWIDTH +: PIX_BITWIDTH] <= pix_next[r][c];
              o_valid   <= 1'b1;
              state_reg <= OUT;
            end
          end
        end

        OUT: begin
          if (!i_wait) begin
            o_valid   <= 1'b0;
            o_ready   <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: begin
          o_valid   <= 1'b0;
          o_ready   <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idct_calculator.sv
// ---------------------------------------------------------------------------
// tb_idct_calculator
//
// Directed bench for idct_calculator: reset state, DC blocks with
// hand-computed results (including both saturation extremes and zero),
// a ramp round trip through a real-valued forward DCT, stalls in PASS1 and
// in OUT, start together with wait, an ignored start while busy, and a
// reset abort in PASS2. Expected pixels follow IDCT_LEVEL_SHIFT_EN.
// ---------------------------------------------------------------------------
module tb_idct_calculator;

`ifdef IDCT_LEVEL_SHIFT_EN
  localparam int OFS = 128;
`else
  localparam int OFS = 0;
`endif
  localparam real PI = 3.14159265358979;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         i_start;
  logic [767:0] i_coef;
  logic         i_wait;
  logic         o_ready;
  logic [511:0] o_pixel;
  logic         o_valid;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  real ar [8][8];

  always #5 clk = ~clk;

  idct_calculator dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_start (i_start),
    .i_coef  (i_coef),
    .i_wait  (i_wait),
    .o_ready (o_ready),
    .o_pixel (o_pixel),
    .o_valid (o_valid)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [767:0] dc_block(input int v);
    logic [767:0] b;
    b = '0;
    b[11:0] = 12'(v);
    return b;
  endfunction

  function automatic logic [511:0] flat(input int v);
    logic [511:0] p;
    for (int i = 0; i < 64; i++) p[i*8 +: 8] = 8'(v + OFS);
    return p;
  endfunction

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // Present a block in the current cycle, which becomes C0.
  task automatic launch(input logic [767:0] coef);
    i_coef  = coef;
    i_start = 1'b1;
    cyc     = 0;
  endtask

  task automatic wait_valid(output int lat);
    while (!o_valid && cyc < 200) tick();
    lat = o_valid ? cyc : -1;
  endtask

  task automatic run_block(input string tag, input logic [767:0] coef, input logic [511:0] exp);
    int lat;
    check({tag, "_ready"}, 512'(o_ready), 512'(1));
    launch(coef);
    tick();
    i_start = 1'b0;
    check({tag, "_busy"}, 512'(o_ready), 512'(0));
    wait_valid(lat);
    check({tag, "_lat"}, 512'(lat), 512'(18));
    check({tag, "_pix"}, o_pixel, exp);
    tick();
    check({tag, "_vld_drop"}, 512'(o_valid), 512'(0));
    check({tag, "_ready19"}, 512'(o_ready), 512'(1));
    check({tag, "_hold"}, o_pixel, exp);
    $display("[TB] block %s latency=%0d", tag, lat);
  endtask

  task automatic round_trip();
    int           x [8][8];
    logic [767:0] cb;
    logic [7:0]   b;
    real          s;
    int           lat, nok, got;
    cb = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) x[i][j] = 16 * i - 8 * j - 20;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        s = 0.0;
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++) s = s + ar[u][i] * real'(x[i][j]) * ar[v][j];
        cb[(u*8+v)*12 +: 12] = 12'(rnd(s));
      end
    launch(cb);
    tick();
    i_start = 1'b0;
    wait_valid(lat);
    check("rt_lat", 512'(lat), 512'(18));
    nok = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        b   = o_pixel[(i*8+j)*8 +: 8];
        got = (OFS != 0) ? int'(b) - OFS : int'($signed(b));
        if (got - x[i][j] <= 1 && got - x[i][j] >= -1) nok++;
      end
    check("rt_within1", 512'(nok), 512'(64));
    $display("[TB] block round_trip latency=%0d within1=%0d", lat, nok);
    tick();
  endtask

  initial begin
    int lat;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++)
        ar[k][n] = ((k == 0) ? $sqrt(0.125) : 0.5) * $cos(real'((2 * n + 1) * k) * PI / 16.0);

    n_rst   = 1'b0;
    i_start = 1'b0;
    i_wait  = 1'b0;
    i_coef  = '0;
    repeat (3) tick();
    n_rst = 1'b1;
    check("rst_ready", 512'(o_ready), 512'(1));
    check("rst_valid", 512'(o_valid), 512'(0));
    check("rst_pixel", o_pixel, 512'(0));

    // DC and saturation blocks, hand-computed through both Q14 passes.
    run_block("dc80",    dc_block(80),    flat(10));
    run_block("dc2047",  dc_block(2047),  flat(127));
    run_block("dcm2048", dc_block(-2048), flat(-128));
    run_block("zero",    dc_block(0),     flat(0));
    run_block("dcm80",   dc_block(-80),   flat(-10));
    run_block("dc8",     dc_block(8),     flat(1));

    round_trip();

    // Stall 5 cycles in PASS1 (C3..C7) and 2 cycles in OUT.
    launch(dc_block(80));
    tick();
    i_start = 1'b0;
    tick();
    tick();
    i_wait = 1'b1;
    repeat (5) tick();
    i_wait = 1'b0;
    check("stall_busy", 512'(o_ready), 512'(0));
    wait_valid(lat);
    check("stall_lat", 512'(lat), 512'(23));
    check("stall_pix23", o_pixel, flat(10));
    i_wait = 1'b1;
    tick();
    check("stall_vld24", 512'(o_valid), 512'(1));
    check("stall_pix24", o_pixel, flat(10));
    tick();
    i_wait = 1'b0;
    check("stall_vld25", 512'(o_valid), 512'(1));
    check("stall_pix25", o_pixel, flat(10));
    tick();
    check("stall_vld26", 512'(o_valid), 512'(0));
    check("stall_ready26", 512'(o_ready), 512'(1));
    $display("[TB] block stall latency=%0d", lat);

    // i_start together with i_wait in IDLE, wait held through C2.
    launch(dc_block(8));
    i_wait = 1'b1;
    tick();
    i_start = 1'b0;
    check("sw_accepted", 512'(o_ready), 512'(0));
    tick();
    tick();
    i_wait = 1'b0;
    wait_valid(lat);
    check("sw_lat", 512'(lat), 512'(20));
    check("sw_pix", o_pixel, flat(1));
    $display("[TB] block start_with_wait latency=%0d", lat);
    tick();

    // Second start at C5 while busy must be ignored.
    launch(dc_block(80));
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    i_coef  = dc_block(2047);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_valid(lat);
    check("busy_lat", 512'(lat), 512'(18));
    check("busy_pix", o_pixel, flat(10));
    $display("[TB] block busy_a latency=%0d", lat);
    tick();
    run_block("busy_b", dc_block(2047), flat(127));

    // Reset abort at C12 (PASS2), then a fresh block.
    launch(dc_block(2047));
    tick();
    i_start = 1'b0;
    while (cyc < 12) tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("abort_ready", 512'(o_ready), 512'(1));
    check("abort_valid", 512'(o_valid), 512'(0));
    check("abort_pixel", o_pixel, 512'(0));
    $display("[TB] block aborted at C12");
    run_block("post_rst", dc_block(-80), flat(-10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
